// File: rtl/riscv_core_rob_ctrl.sv
// 16-entry reorder-buffer controller: in-order alloc, out-of-order fill, in-order commit, two bypass reads.
// Optional RISCV_ROB_FLUSH_EN adds a rob_flush input that discards every in-flight entry.
module riscv_core_rob_ctrl (
  input  logic        clk,
  input  logic        reset,
`ifdef RISCV_ROB_FLUSH_EN
  input  logic        rob_flush,
`endif
  input  logic        rob_alloc_val,
  output logic        rob_alloc_rdy,
  input  logic        rob_alloc_wen,
  input  logic [4:0]  rob_alloc_dst,
  output logic [3:0]  rob_alloc_slot,
  input  logic        rob_fill_val,
  input  logic [3:0]  rob_fill_slot,
  input  logic [31:0] rob_fill_data,
  input  logic [3:0]  rob_byp0_slot,
  input  logic [3:0]  rob_byp1_slot,
  output logic [31:0] rob_byp0_data,
  output logic [31:0] rob_byp1_data,
  output logic        rob_commit_val,
  output logic        rob_commit_wen,
  output logic [3:0]  rob_commit_slot,
  output logic [4:0]  rob_commit_waddr,
  output logic [31:0] rob_commit_wdata
);

  localparam int DEPTH = 16;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] wen_q;
  logic [4:0]       dst_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       head_q;
  logic [3:0]       tail_q;
  logic [4:0]       count_q;

  logic alloc_go;
  logic head_done;
  logic fill_go;

  assign rob_alloc_rdy  = (count_q != 5'd16);
  assign rob_alloc_slot = tail_q;
  assign alloc_go       = rob_alloc_val && rob_alloc_rdy;
  assign fill_go        = rob_fill_val && valid_q[rob_fill_slot];
  assign head_done      = valid_q[head_q] && !pending_q[head_q];

`ifdef RISCV_ROB_FLUSH_EN
  assign rob_commit_val = head_done && !rob_flush;
`else
  assign rob_commit_val = head_done;
`endif
  assign rob_commit_wen   = rob_commit_val && wen_q[head_q];
  assign rob_commit_slot  = head_q;
  assign rob_commit_waddr = dst_q[head_q];
  assign rob_commit_wdata = data_q[head_q];

  // Bypass reads are raw array reads; a same-cycle fill is not forwarded.
  assign rob_byp0_data = data_q[rob_byp0_slot];
  assign rob_byp1_data = data_q[rob_byp1_slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      pending_q <= '0;
      wen_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= '0;
        data_q[i] <= '0;
      end
`ifdef RISCV_ROB_FLUSH_EN
    end else if (rob_flush) begin
      // Flush only drops bookkeeping; payload arrays keep stale contents.
      valid_q   <= '0;
      pending_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
`endif
    end else begin
      if (alloc_go) begin
        valid_q[tail_q]   <= 1'b1;
        pending_q[tail_q] <= 1'b1;
        wen_q[tail_q]     <= rob_alloc_wen;
        dst_q[tail_q]     <= rob_alloc_dst;
        tail_q            <= tail_q + 4'd1;
      end
      if (fill_go) begin
        pending_q[rob_fill_slot] <= 1'b0;
        data_q[rob_fill_slot]    <= rob_fill_data;
      end
      // Head and tail coincide only when empty or full, so commit and alloc never hit one slot.
      if (rob_commit_val) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 4'd1;
      end
      if (alloc_go && !rob_commit_val)
        count_q <= count_q + 5'd1;
      else if (!alloc_go && rob_commit_val)
        count_q <= count_q - 5'd1;
    end
  end

endmodule

// File: tb/tb_riscv_core_rob_ctrl.sv
// Directed self-checking bench for riscv_core_rob_ctrl; flush steps build only with RISCV_ROB_FLUSH_EN.
module tb_riscv_core_rob_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rob_alloc_val;
  logic        rob_alloc_rdy;
  logic        rob_alloc_wen;
  logic [4:0]  rob_alloc_dst;
  logic [3:0]  rob_alloc_slot;
  logic        rob_fill_val;
  logic [3:0]  rob_fill_slot;
  logic [31:0] rob_fill_data;
  logic [3:0]  rob_byp0_slot;
  logic [3:0]  rob_byp1_slot;
  logic [31:0] rob_byp0_data;
  logic [31:0] rob_byp1_data;
  logic        rob_commit_val;
  logic        rob_commit_wen;
  logic [3:0]  rob_commit_slot;
  logic [4:0]  rob_commit_waddr;
  logic [31:0] rob_commit_wdata;
`ifdef RISCV_ROB_FLUSH_EN
  logic        rob_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_core_rob_ctrl dut (
    .clk              (clk),
    .reset            (reset),
`ifdef RISCV_ROB_FLUSH_EN
    .rob_flush        (rob_flush),
`endif
    .rob_alloc_val    (rob_alloc_val),
    .rob_alloc_rdy    (rob_alloc_rdy),
    .rob_alloc_wen    (rob_alloc_wen),
    .rob_alloc_dst    (rob_alloc_dst),
    .rob_alloc_slot   (rob_alloc_slot),
    .rob_fill_val     (rob_fill_val),
    .rob_fill_slot    (rob_fill_slot),
    .rob_fill_data    (rob_fill_data),
    .rob_byp0_slot    (rob_byp0_slot),
    .rob_byp1_slot    (rob_byp1_slot),
    .rob_byp0_data    (rob_byp0_data),
    .rob_byp1_data    (rob_byp1_data),
    .rob_commit_val   (rob_commit_val),
    .rob_commit_wen   (rob_commit_wen),
    .rob_commit_slot  (rob_commit_slot),
    .rob_commit_waddr (rob_commit_waddr),
    .rob_commit_wdata (rob_commit_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic wen, input logic [4:0] dst);
    rob_alloc_val = 1'b1;
    rob_alloc_wen = wen;
    rob_alloc_dst = dst;
    tick();
    rob_alloc_val = 1'b0;
  endtask

  task automatic fill(input logic [3:0] slot, input logic [31:0] data);
    rob_fill_val  = 1'b1;
    rob_fill_slot = slot;
    rob_fill_data = data;
    tick();
    rob_fill_val  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rob_alloc_val = 0; rob_alloc_wen = 0; rob_alloc_dst = 0;
    rob_fill_val = 0; rob_fill_slot = 0; rob_fill_data = 0;
    rob_byp0_slot = 0; rob_byp1_slot = 0;
`ifdef RISCV_ROB_FLUSH_EN
    rob_flush = 0;
`endif
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_rdy", rob_alloc_rdy, 1);
    chk("rst_slot", rob_alloc_slot, 0);
    chk("rst_cval", rob_commit_val, 0);
    chk("rst_cwen", rob_commit_wen, 0);
    chk("rst_cslot", rob_commit_slot, 0);
    chk("rst_waddr", rob_commit_waddr, 0);
    chk("rst_wdata", rob_commit_wdata, 0);
    chk("rst_byp0", rob_byp0_data, 0);

    // Single alloc/fill/commit
    alloc(1'b1, 5'd5);
    chk("a1_slot", rob_alloc_slot, 1);
    chk("a1_pending", rob_commit_val, 0);
    fill(4'd0, 32'hDEAD_BEEF);
    chk("a1_cval", rob_commit_val, 1);
    chk("a1_cwen", rob_commit_wen, 1);
    chk("a1_waddr", rob_commit_waddr, 5);
    chk("a1_wdata", rob_commit_wdata, 32'hDEAD_BEEF);
    chk("a1_cslot", rob_commit_slot, 0);
    tick();
    chk("a1_freed", rob_commit_val, 0);
    chk("a1_head", rob_commit_slot, 1);

    // Out-of-order completion into slots 1..3
    alloc(1'b1, 5'd10);
    alloc(1'b1, 5'd11);
    alloc(1'b1, 5'd12);
    chk("ooo_tail", rob_alloc_slot, 4);
    fill(4'd3, 32'h33);
    chk("ooo_wait3", rob_commit_val, 0);
    fill(4'd2, 32'h22);
    chk("ooo_wait2", rob_commit_val, 0);
    fill(4'd1, 32'h11);
    chk("ooo_c1_val", rob_commit_val, 1);
    chk("ooo_c1_slot", rob_commit_slot, 1);
    chk("ooo_c1_waddr", rob_commit_waddr, 10);
    chk("ooo_c1_wdata", rob_commit_wdata, 32'h11);
    tick();
    chk("ooo_c2_val", rob_commit_val, 1);
    chk("ooo_c2_slot", rob_commit_slot, 2);
    chk("ooo_c2_wdata", rob_commit_wdata, 32'h22);
    tick();
    chk("ooo_c3_val", rob_commit_val, 1);
    chk("ooo_c3_waddr", rob_commit_waddr, 12);
    chk("ooo_c3_wdata", rob_commit_wdata, 32'h33);
    tick();
    chk("ooo_empty", rob_commit_val, 0);

    // Full and wrap from a clean state
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("full_slot", rob_alloc_slot, i);
      chk("full_rdy", rob_alloc_rdy, 1);
      alloc(1'b1, 5'(i + 1));
    end
    chk("full_rdy0", rob_alloc_rdy, 0);
    chk("full_wrap", rob_alloc_slot, 0);
    alloc(1'b1, 5'd31);
    chk("ovf_rdy", rob_alloc_rdy, 0);
    chk("ovf_slot", rob_alloc_slot, 0);
    chk("ovf_cval", rob_commit_val, 0);
    fill(4'd0, 32'hA0);
    chk("full_cval", rob_commit_val, 1);
    chk("full_waddr", rob_commit_waddr, 1);
    chk("full_wdata", rob_commit_wdata, 32'hA0);
    chk("full_rdy_still0", rob_alloc_rdy, 0);
    tick();
    chk("full_rdy1", rob_alloc_rdy, 1);
    chk("full_next", rob_commit_val, 0);

    // Simultaneous alloc and commit at occupancy 8
    do_reset();
    alloc(1'b0, 5'd3);
    for (int i = 1; i < 8; i++) alloc(1'b1, 5'(i));
    fill(4'd0, 32'h55);
    chk("sim_cval", rob_commit_val, 1);
    chk("sim_cwen0", rob_commit_wen, 0);
    chk("sim_waddr", rob_commit_waddr, 3);
    alloc(1'b1, 5'd9);
    chk("sim_tail", rob_alloc_slot, 9);
    chk("sim_head", rob_commit_slot, 1);
    chk("sim_cval_after", rob_commit_val, 0);
    for (int i = 0; i < 7; i++) alloc(1'b1, 5'd20);
    chk("sim_cnt15_rdy", rob_alloc_rdy, 1);
    alloc(1'b1, 5'd21);
    chk("sim_cnt16_rdy", rob_alloc_rdy, 0);

    // Bypass: no same-cycle forwarding, reads ignore valid/pending
    rob_byp0_slot = 4'd7;
    rob_byp1_slot = 4'd7;
    rob_fill_val  = 1'b1;
    rob_fill_slot = 4'd7;
    rob_fill_data = 32'h1234;
    #1;
    chk("byp1_old", rob_byp1_data, 0);
    tick();
    rob_fill_val = 1'b0;
    chk("byp0_new", rob_byp0_data, 32'h1234);
    chk("byp1_new", rob_byp1_data, 32'h1234);
    rob_byp0_slot = 4'd0;
    #1;
    chk("byp0_stale", rob_byp0_data, 32'h55);
    chk("byp_no_commit", rob_commit_val, 0);

    // Reset mid-operation
    rob_byp0_slot = 4'd7;
    do_reset();
    chk("mrst_rdy", rob_alloc_rdy, 1);
    chk("mrst_slot", rob_alloc_slot, 0);
    chk("mrst_cval", rob_commit_val, 0);
    chk("mrst_wdata", rob_commit_wdata, 0);
    chk("mrst_byp0", rob_byp0_data, 0);

`ifdef RISCV_ROB_FLUSH_EN
    // Flush overrides commit and a same-cycle alloc
    for (int i = 0; i < 5; i++) alloc(1'b1, 5'd1);
    fill(4'd0, 32'h77);
    chk("fl_pre_cval", rob_commit_val, 1);
    rob_flush     = 1'b1;
    rob_alloc_val = 1'b1;
    #1;
    chk("fl_cval", rob_commit_val, 0);
    chk("fl_cwen", rob_commit_wen, 0);
    tick();
    rob_flush     = 1'b0;
    rob_alloc_val = 1'b0;
    #1;
    chk("fl_slot", rob_alloc_slot, 0);
    chk("fl_head", rob_commit_slot, 0);
    chk("fl_cval_after", rob_commit_val, 0);
    chk("fl_rdy", rob_alloc_rdy, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
